// File: rtl/game_pkg.sv
// Shared encodings for the 2048 move front end.
package game_pkg;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic SRC_BTN = 1'b0;
    localparam logic SRC_DBG = 1'b1;

    localparam int QUEUE_DEPTH = 2;

    typedef struct packed {
        logic [1:0] dir;
        logic       debug;
    } move_t;

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser, debounce counter, stable level and one-cycle press pulse for one button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   synced;
    logic                   stable;
    logic [CW-1:0]          cnt;

    assign synced = sync[SYNC_STAGES-1];

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
        end
    end

    // Accept a new level only after it has differed from the stable one long enough;
    // rise fires with the accepted 0->1 change so releases never produce events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (synced != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= synced;
                    cnt    <= '0;
                    rise   <= synced;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_move_arbiter.sv
// Merges debounced button presses with the debug command channel into a 2-entry move queue.
module game_move_arbiter
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    input  logic       flush,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       move_debug,
    input  logic       move_ready,
    output logic       overflow
);

    localparam logic [1:0] Q_FULL = 2'(QUEUE_DEPTH);

    logic       rise_l, rise_r, rise_u, rise_d;
    logic       evt_valid;
    logic [1:0] evt_dir;

    logic       pend_valid;
    logic [1:0] pend_dir;
    logic       rr;
    logic       rst_done;
    logic [1:0] count;
    logic       rd_ptr, wr_ptr;
    move_t      mem [QUEUE_DEPTH];

    logic       arb_en, grant_btn, grant_dbg, push, pop;
    move_t      push_entry;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_db_left  (.clk(clk), .rst_n(rst_n), .btn(btn_left),  .rise(rise_l));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_db_right (.clk(clk), .rst_n(rst_n), .btn(btn_right), .rise(rise_r));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_db_up    (.clk(clk), .rst_n(rst_n), .btn(btn_up),    .rise(rise_u));
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES))
        u_db_down  (.clk(clk), .rst_n(rst_n), .btn(btn_down),  .rise(rise_d));

    // Collapse same-cycle presses into one event, LEFT > RIGHT > UP > DOWN.
    always_comb begin
        evt_valid = rise_l | rise_r | rise_u | rise_d;
        evt_dir   = DIR_DOWN;
        if (rise_l)      evt_dir = DIR_LEFT;
        else if (rise_r) evt_dir = DIR_RIGHT;
        else if (rise_u) evt_dir = DIR_UP;
    end

    // Round-robin grant from registered state only; rr names the source that wins the next tie.
    always_comb begin
        arb_en     = rst_done & (count != Q_FULL);
        grant_btn  = arb_en & pend_valid & (~cmd_valid | (rr == SRC_BTN));
        grant_dbg  = arb_en & cmd_valid & (~pend_valid | (rr == SRC_DBG));
        push       = grant_btn | grant_dbg;
        pop        = move_valid & move_ready;
        push_entry = grant_dbg ? move_t'{dir: cmd_dir,  debug: 1'b1}
                               : move_t'{dir: pend_dir, debug: 1'b0};
        cmd_ready  = arb_en & ~(pend_valid & (rr == SRC_BTN));
    end

    assign move_valid = (count != 2'd0);
    assign move_dir   = mem[rd_ptr].dir;
    assign move_debug = mem[rd_ptr].debug;

    // cmd_ready stays low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // Pending event, overflow flag, rr pointer and move FIFO; flush overrides everything here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_dir   <= DIR_LEFT;
            overflow   <= 1'b0;
            rr         <= SRC_BTN;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            pend_valid <= 1'b0;
            overflow   <= 1'b0;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            // A slot frees up in the same cycle the held event is granted.
            if (evt_valid) begin
                if (pend_valid && !grant_btn) begin
                    overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_dir   <= evt_dir;
                end
            end else if (grant_btn) begin
                pend_valid <= 1'b0;
            end

            if (arb_en && pend_valid && cmd_valid) rr <= ~rr;

            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
